r_inst_sequencer: RTL and testbench
===================================

Name: r_inst_sequencer

Overview:
- Multi-cycle control FSM for the R-type CPU datapath (instruction ROM, register file, ALU).
- Drives the PC, the register-file read/write addresses and write enable, and the 3-bit ALU op.
- Latches ALU flags and counts retired instructions.
- Sits inside CPU, between the board-level RST/CLK/switch inputs and the datapath; supports single-step and free-run.

Parameters:
- PC_W, 8, PC width in words; ROM depth is 2^PC_W.
- PROG_LEN, 16, number of valid instructions; execution halts after the instruction at PROG_LEN-1 retires. Range 1..2^PC_W.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RUN  in  1  level; while high, instructions execute back-to-back.
- STEP  in  1  single-cycle pulse; in IDLE, executes exactly one instruction.
- INST  in  32  instruction word from the combinational ROM, addressed by PC.
- ALU_ZF  in  1  ALU zero flag.
- ALU_OF  in  1  ALU signed-overflow flag.
- PC  out  PC_W  instruction address.
- RA  out  5  regfile read port A address (IR[25:21]).
- RB  out  5  regfile read port B address (IR[20:16]).
- WA  out  5  regfile write address (IR[15:11]).
- WE  out  1  regfile write enable.
- ALU_OP  out  3  ALU operation select.
- IR  out  32  latched instruction; feeds dbg_inst.
- BUSY  out  1  high in any state other than IDLE and HALT.
- HALTED  out  1  high in HALT.
- ILLEGAL  out  1  sticky; set on an undecodable instruction.
- ZF_Q  out  1  ALU_ZF registered at the end of EXEC.
- OF_Q  out  1  ALU_OF registered at the end of EXEC.
- RETIRED  out  CNT_W  count of instructions that completed WB.

Behaviour:
- Reset: state IDLE; all outputs 0 (PC, RA, RB, WA, WE, ALU_OP, IR, flags, RETIRED, ILLEGAL). A reset in any state, including WB, wins over everything; WE is low from the next edge.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. All outputs are registered.
- IDLE: RUN=1 or STEP=1 -> FETCH. If both are high, the result is the same as RUN alone.
- FETCH (1 cycle): IR <= INST; -> DECODE.
- DECODE (1 cycle):
  - RA, RB, WA are driven from IR.
  - Decode per the rules below; -> EXEC.
- EXEC (1 cycle): ALU_OP is stable; ZF_Q/OF_Q are sampled at the end of the cycle; -> WB.
- WB (1 cycle):
  - WE=1 for exactly this cycle, unless suppressed.
  - RETIRED += 1; wraps modulo 2^CNT_W.
  - If PC == PROG_LEN-1 -> HALT, and PC is not incremented.
  - Otherwise PC += 1; then RUN=1 -> FETCH, else -> IDLE.
- Throughput is 4 cycles per instruction under RUN.
- STEP pulses seen outside IDLE are ignored, not queued. Deasserting RUN mid-instruction completes the current instruction, then goes to IDLE.
- HALT: holds all registers, WE=0, HALTED=1; leaves only on RST.
- Decode rules:
  - Opcode IR[31:26] must be 0.
  - funct IR[5:0] to ALU_OP: 100100 AND=000, 100101 OR=001, 100000 ADD=010, 100110 XOR=011, 100111 NOR=100, 000010 SRL=101, 100010 SUB=110, 101010 SLT=111.
  - IR == 0 (NOP): ALU_OP=000, WE suppressed, still retires.
  - Nonzero opcode or unlisted funct: ILLEGAL <= 1, WE suppressed, still retires, PC advances.
- WA == 0 suppresses WE ($zero is never written).
- ALU_OP holds its last value between instructions. PC wraps to 0 only if PROG_LEN = 2^PC_W, which cannot occur because HALT is entered first.

Optional Feature:
- Macro OF_TRAP_EN.
- Defined: in WB, an ADD or SUB with OF_Q=1 suppresses WE and does not increment RETIRED. The FSM goes to HALT with PC holding the trapping instruction's address.
- Undefined: overflow only sets OF_Q; writeback and retirement are unconditional.

Test Plan:
- Reset mid-WB (RST asserted in the WB cycle with RUN=1) -> next cycle: state IDLE, WE=0, PC=0, RETIRED=0, ILLEGAL=0.
- STEP pulse, INST=0x00221820 (add $3,$1,$2) -> FETCH/DECODE/EXEC/WB over 4 cycles, RA=1, RB=2, WA=3, ALU_OP=010, WE high 1 cycle, PC 0->1, RETIRED=1, returns to IDLE. Extra STEP pulses during BUSY are ignored.
- RUN=1 with PROG_LEN=4, ROM holding AND/OR/SUB/SLT -> ALU_OP sequence 000,001,110,111 at 4-cycle spacing, HALTED=1 after 16 cycles, PC=3, RETIRED=4.
- INST=0x8C000000 (lw) then 0x00000000 -> ILLEGAL=1 sticky, WE never asserted, RETIRED=2. rd=0 case (0x00220020) -> WE stays 0.
- ADD with ALU_OF=1, ALU_ZF=1 in EXEC -> OF_Q=1, ZF_Q=1 after EXEC. With OF_TRAP_EN: WE=0, HALT, RETIRED unchanged. Without OF_TRAP_EN: WE=1, PC advances.

Source files
------------

// File: rtl/r_inst_sequencer_if.sv
// Sequencer <-> datapath bundle.
// master: the sequencer (drives PC, regfile addresses/enable, ALU op, status).
// slave : the CPU/datapath side (drives RUN/STEP, ROM word and ALU flags).
// Ports : RUN, STEP, INST, ALU_ZF, ALU_OF in; PC, RA, RB, WA, WE, ALU_OP, IR,
//         BUSY, HALTED, ILLEGAL, ZF_Q, OF_Q, RETIRED out (from the master view).
interface r_inst_sequencer_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);
  logic             RUN;
  logic             STEP;
  logic [31:0]      INST;
  logic             ALU_ZF;
  logic             ALU_OF;
  logic [PC_W-1:0]  PC;
  logic [4:0]       RA;
  logic [4:0]       RB;
  logic [4:0]       WA;
  logic             WE;
  logic [2:0]       ALU_OP;
  logic [31:0]      IR;
  logic             BUSY;
  logic             HALTED;
  logic             ILLEGAL;
  logic             ZF_Q;
  logic             OF_Q;
  logic [CNT_W-1:0] RETIRED;

  modport master (
    input  RUN, STEP, INST, ALU_ZF, ALU_OF,
    output PC, RA, RB, WA, WE, ALU_OP, IR, BUSY, HALTED, ILLEGAL, ZF_Q, OF_Q, RETIRED
  );

  modport slave (
    output RUN, STEP, INST, ALU_ZF, ALU_OF,
    input  PC, RA, RB, WA, WE, ALU_OP, IR, BUSY, HALTED, ILLEGAL, ZF_Q, OF_Q, RETIRED
  );
endinterface

// File: rtl/r_inst_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM for the R-type datapath.
// Ports: CLK, RST (synchronous, active-high), bus (r_inst_sequencer_if.master).
// Optional macro OF_TRAP_EN: ADD/SUB overflow suppresses writeback and
// retirement and halts with PC on the trapping instruction.
module r_inst_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned PROG_LEN = 16,
  parameter int unsigned CNT_W    = 16
) (
  input logic                CLK,
  input logic                RST,
  r_inst_sequencer_if.master bus
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [4:0]       ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
  logic             we_q, we_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      ir_q, ir_d;
  logic             busy_q, busy_d, halted_q, halted_d;
  logic             ill_q, ill_d, zf_q, zf_d, of_q, of_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             wb_ok_q, wb_ok_d;   // writeback allowed for the current instruction
  logic             dec_legal, dec_nop;
  logic [2:0]       dec_op;
`ifdef OF_TRAP_EN
  logic             arith_q, arith_d;   // current instruction is ADD or SUB
  logic             dec_arith;
`endif

  // Instruction decode from the latched IR
  always_comb begin
    dec_legal = 1'b1;
    dec_nop   = 1'b0;
    dec_op    = op_q;
`ifdef OF_TRAP_EN
    dec_arith = 1'b0;
`endif
    if (ir_q == 32'd0) begin
      dec_nop = 1'b1;
      dec_op  = 3'b000;
    end else if (ir_q[31:26] != 6'd0) begin
      dec_legal = 1'b0;
    end else begin
      unique case (ir_q[5:0])
        6'b100100: dec_op = 3'b000;
        6'b100101: dec_op = 3'b001;
        6'b100000: dec_op = 3'b010;
        6'b100110: dec_op = 3'b011;
        6'b100111: dec_op = 3'b100;
        6'b000010: dec_op = 3'b101;
        6'b100010: dec_op = 3'b110;
        6'b101010: dec_op = 3'b111;
        default:   dec_legal = 1'b0;
      endcase
`ifdef OF_TRAP_EN
      dec_arith = dec_legal && (ir_q[5:0] == 6'b100000 || ir_q[5:0] == 6'b100010);
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    wa_d    = wa_q;
    we_d    = 1'b0;
    op_d    = op_q;
    ir_d    = ir_q;
    ill_d   = ill_q;
    zf_d    = zf_q;
    of_d    = of_q;
    ret_d   = ret_q;
    wb_ok_d = wb_ok_q;
`ifdef OF_TRAP_EN
    arith_d = arith_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.RUN || bus.STEP) state_d = S_FETCH;
      end
      S_FETCH: begin
        // Address fields are loaded alongside IR so they are valid throughout DECODE
        ir_d    = bus.INST;
        ra_d    = bus.INST[25:21];
        rb_d    = bus.INST[20:16];
        wa_d    = bus.INST[15:11];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = dec_op;
        ill_d   = ill_q | ~dec_legal;
        wb_ok_d = dec_legal && !dec_nop && (wa_q != 5'd0);
`ifdef OF_TRAP_EN
        arith_d = dec_arith;
`endif
        state_d = S_EXEC;
      end
      S_EXEC: begin
        zf_d    = bus.ALU_ZF;
        of_d    = bus.ALU_OF;
        we_d    = wb_ok_q;
`ifdef OF_TRAP_EN
        // OF_Q is being sampled on this same edge, so use the live flag
        if (arith_q && bus.ALU_OF) we_d = 1'b0;
`endif
        state_d = S_WB;
      end
      S_WB: begin
`ifdef OF_TRAP_EN
        if (arith_q && of_q) begin
          state_d = S_HALT;
        end else
`endif
        begin
          ret_d = ret_q + CNT_W'(1);
          if (pc_q == LAST_PC) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = bus.RUN ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Output and datapath-control registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      wa_q     <= '0;
      we_q     <= 1'b0;
      op_q     <= '0;
      ir_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
      ret_q    <= '0;
      wb_ok_q  <= 1'b0;
`ifdef OF_TRAP_EN
      arith_q  <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      wa_q     <= wa_d;
      we_q     <= we_d;
      op_q     <= op_d;
      ir_q     <= ir_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
      zf_q     <= zf_d;
      of_q     <= of_d;
      ret_q    <= ret_d;
      wb_ok_q  <= wb_ok_d;
`ifdef OF_TRAP_EN
      arith_q  <= arith_d;
`endif
    end
  end

  assign bus.PC      = pc_q;
  assign bus.RA      = ra_q;
  assign bus.RB      = rb_q;
  assign bus.WA      = wa_q;
  assign bus.WE      = we_q;
  assign bus.ALU_OP  = op_q;
  assign bus.IR      = ir_q;
  assign bus.BUSY    = busy_q;
  assign bus.HALTED  = halted_q;
  assign bus.ILLEGAL = ill_q;
  assign bus.ZF_Q    = zf_q;
  assign bus.OF_Q    = of_q;
  assign bus.RETIRED = ret_q;

endmodule

// File: tb/tb_r_inst_sequencer.sv
// Directed bench for r_inst_sequencer with PROG_LEN=4 and a behavioural ROM.
module tb_r_inst_sequencer;

  localparam int unsigned PC_W     = 8;
  localparam int unsigned PROG_LEN = 4;
  localparam int unsigned CNT_W    = 16;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_AND  = 32'h0022_1824;
  localparam logic [31:0] I_OR   = 32'h0022_1825;
  localparam logic [31:0] I_SUB  = 32'h0022_1822;
  localparam logic [31:0] I_SLT  = 32'h0022_182A;
  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_ADD0 = 32'h0022_0020;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] rom [0:(1<<PC_W)-1];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        we_seen;
  logic [2:0]  exp_ops [0:3];

  r_inst_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  r_inst_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.INST = rom[bus.PC];

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.WE === 1'b1) we_seen = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.RUN = 1'b0;
    bus.STEP = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // One STEP pulse followed by the remaining cycles of one instruction
  task automatic step_one();
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) rom[i] = 32'd0;
    bus.RUN    = 1'b0;
    bus.STEP   = 1'b0;
    bus.ALU_ZF = 1'b0;
    bus.ALU_OF = 1'b0;
    we_seen    = 1'b0;

    // Reset state
    do_reset();
    chk("rst_pc", 64'(bus.PC), 64'd0);
    chk("rst_we", 64'(bus.WE), 64'd0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_halted", 64'(bus.HALTED), 64'd0);
    chk("rst_retired", 64'(bus.RETIRED), 64'd0);
    chk("rst_ir", 64'(bus.IR), 64'd0);

    // Single step of add $3,$1,$2 with extra STEP pulses while busy
    rom[0] = I_ADD;
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    chk("step_fetch_busy", 64'(bus.BUSY), 64'd1);
    tick();
    chk("step_ir", 64'(bus.IR), 64'(I_ADD));
    chk("step_ra", 64'(bus.RA), 64'd1);
    chk("step_rb", 64'(bus.RB), 64'd2);
    chk("step_wa", 64'(bus.WA), 64'd3);
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    chk("step_exec_op", 64'(bus.ALU_OP), 64'b010);
    chk("step_exec_we", 64'(bus.WE), 64'd0);
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    chk("step_wb_we", 64'(bus.WE), 64'd1);
    chk("step_wb_pc", 64'(bus.PC), 64'd0);
    tick();
    chk("step_done_we", 64'(bus.WE), 64'd0);
    chk("step_done_pc", 64'(bus.PC), 64'd1);
    chk("step_done_ret", 64'(bus.RETIRED), 64'd1);
    chk("step_done_busy", 64'(bus.BUSY), 64'd0);
    tick();
    tick();
    chk("step_not_queued", 64'(bus.BUSY), 64'd0);

    // Free run over AND/OR/SUB/SLT until halt
    do_reset();
    rom[0] = I_AND; rom[1] = I_OR; rom[2] = I_SUB; rom[3] = I_SLT;
    exp_ops[0] = 3'b000; exp_ops[1] = 3'b001; exp_ops[2] = 3'b110; exp_ops[3] = 3'b111;
    bus.RUN = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick();
      if (cyc % 4 == 3) chk($sformatf("run_op%0d", cyc / 4), 64'(bus.ALU_OP), 64'(exp_ops[cyc / 4]));
      if (cyc % 4 == 0) chk($sformatf("run_we%0d", cyc / 4), 64'(bus.WE), 64'd1);
      if (cyc == 16) chk("run_not_halted_yet", 64'(bus.HALTED), 64'd0);
    end
    chk("run_halted", 64'(bus.HALTED), 64'd1);
    chk("run_pc", 64'(bus.PC), 64'd3);
    chk("run_retired", 64'(bus.RETIRED), 64'd4);
    chk("run_busy", 64'(bus.BUSY), 64'd0);
    bus.RUN = 1'b0;
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    tick();
    tick();
    chk("halt_sticky", 64'(bus.HALTED), 64'd1);
    chk("halt_we", 64'(bus.WE), 64'd0);
    chk("halt_retired", 64'(bus.RETIRED), 64'd4);

    // Illegal opcode, NOP, rd=0, then last instruction halts
    do_reset();
    rom[0] = I_LW; rom[1] = 32'd0; rom[2] = I_ADD0; rom[3] = 32'd0;
    we_seen = 1'b0;
    step_one();
    chk("ill_set", 64'(bus.ILLEGAL), 64'd1);
    chk("ill_pc", 64'(bus.PC), 64'd1);
    step_one();
    chk("ill_sticky", 64'(bus.ILLEGAL), 64'd1);
    chk("nop_op", 64'(bus.ALU_OP), 64'b000);
    chk("ill_nop_retired", 64'(bus.RETIRED), 64'd2);
    step_one();
    chk("rd0_op", 64'(bus.ALU_OP), 64'b010);
    chk("rd0_retired", 64'(bus.RETIRED), 64'd3);
    chk("no_we_seen", 64'(we_seen), 64'd0);
    step_one();
    chk("last_halted", 64'(bus.HALTED), 64'd1);
    chk("last_pc", 64'(bus.PC), 64'd3);
    chk("last_retired", 64'(bus.RETIRED), 64'd4);

    // ADD with overflow and zero flags during EXEC
    do_reset();
    rom[0] = I_ADD;
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    tick();
    tick();
    bus.ALU_OF = 1'b1;
    bus.ALU_ZF = 1'b1;
    tick();
    bus.ALU_OF = 1'b0;
    bus.ALU_ZF = 1'b0;
    chk("of_q", 64'(bus.OF_Q), 64'd1);
    chk("zf_q", 64'(bus.ZF_Q), 64'd1);
`ifdef OF_TRAP_EN
    chk("of_wb_we", 64'(bus.WE), 64'd0);
    tick();
    chk("of_halted", 64'(bus.HALTED), 64'd1);
    chk("of_pc", 64'(bus.PC), 64'd0);
    chk("of_retired", 64'(bus.RETIRED), 64'd0);
`else
    chk("of_wb_we", 64'(bus.WE), 64'd1);
    tick();
    chk("of_halted", 64'(bus.HALTED), 64'd0);
    chk("of_pc", 64'(bus.PC), 64'd1);
    chk("of_retired", 64'(bus.RETIRED), 64'd1);
`endif

    // Reset asserted during the WB cycle of the second instruction
    do_reset();
    rom[0] = I_LW; rom[1] = I_ADD;
    bus.RUN = 1'b1;
    repeat (8) tick();
    chk("mid_wb_we", 64'(bus.WE), 64'd1);
    chk("mid_wb_ill", 64'(bus.ILLEGAL), 64'd1);
    chk("mid_wb_ret", 64'(bus.RETIRED), 64'd1);
    RST = 1'b1;
    tick();
    chk("rstwb_we", 64'(bus.WE), 64'd0);
    chk("rstwb_busy", 64'(bus.BUSY), 64'd0);
    chk("rstwb_pc", 64'(bus.PC), 64'd0);
    chk("rstwb_ret", 64'(bus.RETIRED), 64'd0);
    chk("rstwb_ill", 64'(bus.ILLEGAL), 64'd0);
    RST = 1'b0;
    bus.RUN = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
